// File: rtl/fios_result_collector_pkg.sv
// Shared types and constants for the FIOS result collector.
package fios_pkg;

  localparam int DEF_WORD_WIDTH = 17;
  localparam int DEF_S          = 8;

  typedef logic [DEF_WORD_WIDTH-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } collector_state_e;

  // Word-counter width; at least one bit even for single-word products.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fios_result_collector_if.sv
// Result-stream input and reduced-product output bundle of the collector.
//
// Handshake: res_valid_i qualifies res_i for one cycle with no back-pressure.
// result_o is transferred on any cycle where result_valid_o and result_ready_i
// are both high; while result_valid_o=1 and result_ready_i=0 result_o holds.
interface fios_result_collector_if #(
  parameter int WORD_WIDTH = 17,
  parameter int s          = 8
);
  logic                    res_valid_i;
  logic [WORD_WIDTH-1:0]   res_i;
  logic [s*WORD_WIDTH-1:0] p_i;
  logic                    flush_i;
  logic [s*WORD_WIDTH-1:0] result_o;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic                    busy_o;
  logic                    overrun_o;

  modport master (
    output res_valid_i, res_i, p_i, flush_i, result_ready_i,
    input  result_o, result_valid_o, busy_o, overrun_o
  );

  modport slave (
    input  res_valid_i, res_i, p_i, flush_i, result_ready_i,
    output result_o, result_valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/fios_result_collector_word_sub.sv
// One-word subtract-with-borrow: {borrow_out, diff} = a - b - borrow_in.
module fios_word_sub #(
  parameter int WORD_WIDTH = 17
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  borrow_in,
  output logic [WORD_WIDTH-1:0] diff,
  output logic                  borrow_out
);

  logic [WORD_WIDTH:0] wide;

  // One bit wider than a word so the MSB carries the borrow-out.
  always_comb begin
    wide       = {1'b0, a} - {1'b0, b} - {{WORD_WIDTH{1'b0}}, borrow_in};
    diff       = wide[WORD_WIDTH-1:0];
    borrow_out = wide[WORD_WIDTH];
  end

endmodule

// File: rtl/fios_result_collector.sv
// Collects the word-serial Montgomery result, performs the final conditional
// subtraction on the fly and presents the reduced product behind valid/ready.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int s          = DEF_S
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  fios_result_collector_if.slave  bus,
  output collector_state_e        dbg_state_o
);

  localparam int CW = cnt_width(s);
  localparam int PW = s * WORD_WIDTH;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  borrow_q, borrow_d;
  logic [PW-1:0]         t_q, t_d;
  logic [PW-1:0]         d_q, d_d;
  logic [PW-1:0]         out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic [WORD_WIDTH-1:0] p_word;
  logic [WORD_WIDTH-1:0] diff_w;
  logic                  bout_w;
  logic                  accept;
  logic                  last;
  logic [PW-1:0]         sel;

  // Pick the modulus word aligned with the incoming result word.
  always_comb begin
    p_word = '0;
    for (int i = 0; i < s; i++) begin
      if (cnt_q == CW'(i)) p_word = bus.p_i[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  fios_word_sub #(.WORD_WIDTH(WORD_WIDTH)) u_word_sub (
    .a          (bus.res_i),
    .b          (p_word),
    .borrow_in  (borrow_q),
    .diff       (diff_w),
    .borrow_out (bout_w)
  );

  // Counter, borrow chain, T/D buffers, selection and output handshake.
  always_comb begin
    accept   = bus.res_valid_i && !bus.flush_i;
    last     = accept && (cnt_q == CW'(s - 1));
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    t_d      = t_q;
    d_d      = d_q;
    out_d    = out_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    if (accept) begin
      for (int i = 0; i < s; i++) begin
        if (cnt_q == CW'(i)) begin
          t_d[i*WORD_WIDTH +: WORD_WIDTH] = bus.res_i;
          d_d[i*WORD_WIDTH +: WORD_WIDTH] = diff_w;
        end
      end
    end

    if (bus.flush_i) begin
      cnt_d    = '0;
      borrow_d = 1'b0;
    end else if (accept) begin
      cnt_d    = last ? '0 : cnt_q + 1'b1;
      borrow_d = last ? 1'b0 : bout_w;
    end

    // Final borrow set means T < p, so T is already reduced.
    sel = bout_w ? t_d : d_d;

    if (last) begin
      if (!valid_q || bus.result_ready_i) begin
        out_d   = sel;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (bus.result_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Control and output state with asynchronous reset.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Word buffers are always overwritten before use, so they carry no reset.
  always_ff @(posedge clock_i) begin
    t_q <= t_d;
    d_q <= d_d;
  end

  // Outputs come straight from flops.
  always_comb begin
    bus.result_o       = out_q;
    bus.result_valid_o = valid_q;
    bus.busy_o         = (cnt_q != '0);
    bus.overrun_o      = ovr_q;
    dbg_state_o        = (cnt_q != '0) ? COLLECT : IDLE;
  end

endmodule

// File: doc/fios_result_collector.md
# fios_result_collector

Downstream stage of the cascaded FIOS Montgomery multiplier. Captures the word-serial result stream (one WORD_WIDTH word per cycle, least-significant word first, s words per product) and applies the Montgomery final conditional subtraction on the fly, computing T − p word by word with a borrow chain. Presents the fully reduced product (T < p) as one parallel word behind a valid/ready handshake.

## Interface
- WORD_WIDTH, 17: width of one result word; matches the multiplier word size.
- s, 8: number of words per product.
- clock_i  in  1: rising-edge clock.
- reset_n_i  in  1: reset, asynchronous, active-low.
- res_valid_i  in  1: res_i carries a valid word this cycle.
- res_i  in  WORD_WIDTH: result word from the multiplier RES_o.
- p_i  in  s*WORD_WIDTH: modulus; must be stable from the first word to the last word of a product.
- flush_i  in  1: synchronous abort of the collection in progress.
- result_o  out  s*WORD_WIDTH: reduced product.
- result_valid_o  out  1: result_o valid.
- result_ready_i  in  1: consumer accepts result_o.
- busy_o  out  1: a collection is in progress (word count > 0).
- overrun_o  out  1: sticky flag; a completed product was dropped. Cleared only by reset.

## Operation
- Collector states:
  - IDLE: cnt = 0.
  - COLLECT: 0 < cnt < s.
- Each cycle with res_valid_i = 1:
  - T word[cnt] <= res_i.
  - D word[cnt] <= res_i − p word[cnt] − borrow; borrow is updated.
  - cnt increments.
- Gaps with res_valid_i = 0 stall the collection. cnt and borrow hold.
- The first word of a product uses borrow_in = 0. Borrow resets to 0 on completion and on flush.
- Completion occurs when the word at cnt = s−1 is accepted. Selection uses the final borrow, including the last word computed combinationally:
  - Final borrow = 1 (T < p): select T.
  - Final borrow = 0 (T ≥ p): select D.
  - The multiplier guarantees T < 2p, so a single subtraction is sufficient.
- Output register: out_q, with result_valid_o.
  - On completion, if result_valid_o = 0 or result_ready_i = 1 in the same cycle, load out_q with the selection and set result_valid_o = 1.
  - Otherwise, drop the new product, keep out_q unchanged and set overrun_o.
- A handshake with result_ready_i = 1 and no completion in that cycle clears result_valid_o.
- The collection buffer frees at completion. Word 0 of the next product may arrive in the very next cycle, with no bubble.
- flush_i takes precedence over res_valid_i in the same cycle. It sets cnt = 0 and borrow = 0. It does not affect out_q, result_valid_o or overrun_o.
- Reset values: cnt 0, borrow 0, result_o 0, result_valid_o 0, busy_o 0, overrun_o 0. The T/D buffers need no reset.
- Arithmetic: the per-word subtraction is WORD_WIDTH+1 bits wide, and the MSB is the borrow-out. All values are unsigned.

## Timing
- Latency: the last word is accepted at edge k, and result_valid_o is high after edge k. It is visible in cycle k+1, which is 1 cycle.
- Throughput: one product every s cycles, sustained without stalls, provided the consumer asserts ready within s−1 cycles of valid.
- result_o is stable while result_valid_o = 1 and result_ready_i = 0.
- Reset asserted mid-collection: all state clears asynchronously. A partial product is never emitted, and the first valid word after release is treated as word 0.
- No combinational path from res_i or result_ready_i to any output.

## Structure
- Package fios_pkg:
  - word_t typedef (logic [WORD_WIDTH-1:0]).
  - Collector state enum {IDLE, COLLECT}.
  - clog2-based counter width constant.
- Sub-module fios_word_sub: one-word subtract-with-borrow (a, b, borrow_in → diff, borrow_out). It is combinational and instantiated once; the borrow register lives in the parent.
- Parent contents: counter, T/D buffers, selection mux and output handshake register.

## Test plan
All scenarios use WORD_WIDTH=4, s=2 and p=0x5B.
- Stream words 0x3, 0x6 (T=0x63) back-to-back, ready=1 → result_o=0x08, valid high for one cycle, one cycle after word 1.
- Stream T=0x40 → result_o=0x40 (borrow set, T selected). Stream T=0x5B → result_o=0x00.
- Stream T=0x63 with a 3-cycle res_valid_i gap between words → result_o=0x08; busy_o stays high across the gap.
- ready=0 and two products back-to-back (0x63 then 0x40) → result_o stays 0x08, overrun_o=1. Raising ready then clears valid.
- Completion coincides with ready=1 while valid is already high → the old result handshakes and the new result loads the next cycle, with no overrun.
- flush_i after word 0, then T=0x40 → result 0x40. Repeat with reset_n_i pulsed low after word 0 → all outputs 0, and the next two words form a clean product.
